// File: rtl/clock_time_counter.sv
// Timekeeping core: 1 Hz prescaler, 24-hour binary H:M:S counters and a
// two-button set mode (mode cycles RUN -> SET_HOUR -> SET_MIN -> RUN,
// inc advances the selected field with wrap).
module clock_time_counter #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       mode_btn_i,
  input  logic       inc_btn_i,
  output logic [5:0] hours_o,
  output logic [5:0] minutes_o,
  output logic [5:0] seconds_o,
  output logic [1:0] mode_o,
  output logic       tick_o
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [5:0] HOUR_MAX = 6'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [5:0] SEC_MAX  = 6'd59;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } mode_t;

  mode_t            mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       hr_q, hr_d;
  logic [5:0]       min_q, min_d;
  logic [5:0]       sec_q, sec_d;
  logic             tick_q, tick_d;

  logic             mode_hist_q;
  logic             inc_hist_q;
  logic             mode_press;
  logic             inc_press;

  // Compare-and-wrap increment; avoids modulo of wider arithmetic.
  function automatic logic [5:0] wrap_inc(input logic [5:0] v,
                                          input logic [5:0] max_v);
    return (v == max_v) ? '0 : v + 6'd1;
  endfunction

  // Rising-edge detect; history resets high so a button held through
  // reset does not register as a press.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      mode_hist_q <= 1'b1;
      inc_hist_q  <= 1'b1;
    end else begin
      mode_hist_q <= mode_btn_i;
      inc_hist_q  <= inc_btn_i;
    end
  end

  assign mode_press = mode_btn_i & ~mode_hist_q;
  assign inc_press  = inc_btn_i  & ~inc_hist_q;

  // State register for mode, prescaler, time fields and tick pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      mode_q <= RUN;
      cnt_q  <= '0;
      hr_q   <= '0;
      min_q  <= '0;
      sec_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      hr_q   <= hr_d;
      min_q  <= min_d;
      sec_q  <= sec_d;
      tick_q <= tick_d;
    end
  end

  // Next-state logic: a mode press always takes priority over both an inc
  // press and a coincident prescaler wrap.
  always_comb begin
    mode_d = mode_q;
    cnt_d  = cnt_q;
    hr_d   = hr_q;
    min_d  = min_q;
    sec_d  = sec_q;
    tick_d = 1'b0;

    unique case (mode_q)
      RUN: begin
        if (mode_press) begin
          mode_d = SET_HOUR;
          cnt_d  = '0;
          sec_d  = '0;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          // Full H:M:S carry chain resolves within this single update.
          if (sec_q == SEC_MAX) begin
            sec_d = '0;
            if (min_q == MIN_MAX) begin
              min_d = '0;
              hr_d  = wrap_inc(hr_q, HOUR_MAX);
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      SET_HOUR: begin
        cnt_d = '0;
        sec_d = '0;
        if (mode_press) begin
          mode_d = SET_MIN;
        end else if (inc_press) begin
          hr_d = wrap_inc(hr_q, HOUR_MAX);
        end
      end

      SET_MIN: begin
        cnt_d = '0;
        sec_d = '0;
        if (mode_press) begin
          mode_d = RUN;
        end else if (inc_press) begin
          min_d = wrap_inc(min_q, MIN_MAX);
        end
      end

      default: begin
        mode_d = RUN;
        cnt_d  = '0;
        sec_d  = '0;
      end
    endcase
  end

  assign hours_o   = hr_q;
  assign minutes_o = min_q;
  assign seconds_o = sec_q;
  assign mode_o    = mode_q;
  assign tick_o    = tick_q;

endmodule

// File: tb/tb_clock_time_counter.sv
// Directed bench for clock_time_counter with TICK_DIV = 4.
module tb_clock_time_counter;

  logic       clk;
  logic       rst_n;
  logic       mode_btn;
  logic       inc_btn;
  logic [5:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [1:0] mode;
  logic       tick;

  int n_tests = 0;
  int n_fail  = 0;

  clock_time_counter #(.TICK_DIV(4)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .mode_btn_i (mode_btn),
    .inc_btn_i  (inc_btn),
    .hours_o    (hours),
    .minutes_o  (minutes),
    .seconds_o  (seconds),
    .mode_o     (mode),
    .tick_o     (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, ".hours"},   32'(hours),   32'(h));
    chk({tag, ".minutes"}, 32'(minutes), 32'(m));
    chk({tag, ".seconds"}, 32'(seconds), 32'(s));
  endtask

  // One press: high for one edge, then low for one edge so the next press
  // sees a fresh rising edge. Returns at the negedge one cycle after effect.
  task automatic press_mode();
    mode_btn = 1'b1;
    @(negedge clk);
    mode_btn = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      inc_btn = 1'b1;
      @(negedge clk);
      inc_btn = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    mode_btn = 1'b0;
    inc_btn  = 1'b0;

    // 1. Reset and tick
    repeat (3) @(negedge clk);
    chk_time("rst", 0, 0, 0);
    chk("rst.mode", 32'(mode), 32'd0);
    chk("rst.tick", 32'(tick), 32'd0);
    rst_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      chk($sformatf("tick.c%0d.tick", c), 32'(tick), (c % 4 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("tick.c%0d.sec", c), 32'(seconds), 32'(c / 4));
    end

    // 2. Full rollover
    press_mode();
    chk("set_hour.mode", 32'(mode), 32'd1);
    chk("set_hour.sec", 32'(seconds), 32'd0);
    press_inc(23);
    chk("hours23", 32'(hours), 32'd23);
    press_mode();
    chk("set_min.mode", 32'(mode), 32'd2);
    press_inc(59);
    chk_time("set2359", 23, 59, 0);
    press_mode();
    chk("run.mode", 32'(mode), 32'd0);
    // Mode edge Em was one cycle ago; ticks land at Em+4k.
    repeat (235) @(negedge clk);
    chk_time("pre_roll", 23, 59, 59);
    chk("pre_roll.tick", 32'(tick), 32'd1);
    repeat (3) @(negedge clk);
    chk_time("hold_roll", 23, 59, 59);
    chk("hold_roll.tick", 32'(tick), 32'd0);
    @(negedge clk);
    chk_time("roll", 0, 0, 0);
    chk("roll.tick", 32'(tick), 32'd1);

    // 3. Set-field wrap
    press_mode();
    press_inc(5);
    chk("hr_start", 32'(hours), 32'd5);
    for (int i = 0; i < 24; i++) begin
      press_inc(1);
      chk("wrap_h.sec", 32'(seconds), 32'd0);
      chk("wrap_h.tick", 32'(tick), 32'd0);
    end
    chk("wrap_h.hours", 32'(hours), 32'd5);
    press_mode();
    press_inc(61);
    chk_time("wrap_m", 5, 1, 0);
    chk("wrap_m.tick", 32'(tick), 32'd0);

    // 4. Simultaneous presses in SET_HOUR
    press_mode();
    press_mode();
    chk("sim.pre_mode", 32'(mode), 32'd1);
    mode_btn = 1'b1;
    inc_btn  = 1'b1;
    @(negedge clk);
    chk("sim.mode", 32'(mode), 32'd2);
    chk("sim.hours", 32'(hours), 32'd5);
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    @(negedge clk);

    // 5. Held inc, then mode held across reset release
    inc_btn = 1'b1;
    repeat (10) @(negedge clk);
    inc_btn = 1'b0;
    @(negedge clk);
    chk("held_inc.min", 32'(minutes), 32'd2);
    rst_n    = 1'b0;
    mode_btn = 1'b1;
    repeat (2) @(negedge clk);
    chk("held_rst.mode", 32'(mode), 32'd0);
    chk_time("held_rst", 0, 0, 0);
    rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("held_mode.c%0d", c), 32'(mode), 32'd0);
    end
    mode_btn = 1'b0;
    @(negedge clk);
    chk("held_mode.release", 32'(mode), 32'd0);

    // 6. Reset mid-set at 14:37
    press_mode();
    press_inc(14);
    press_mode();
    press_inc(37);
    chk_time("mid_set", 14, 37, 0);
    chk("mid_set.mode", 32'(mode), 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    chk_time("mid_rst", 0, 0, 0);
    chk("mid_rst.mode", 32'(mode), 32'd0);
    chk("mid_rst.tick", 32'(tick), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst.c3.tick", 32'(tick), 32'd0);
    chk("mid_rst.c3.sec", 32'(seconds), 32'd0);
    @(negedge clk);
    chk("mid_rst.c4.tick", 32'(tick), 32'd1);
    chk("mid_rst.c4.sec", 32'(seconds), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_time_counter.md
Name: clock_time_counter

Overview:
- Timekeeping core of the multimodal digital clock.
- Divides the system clock down to a 1 Hz tick and keeps binary hours, minutes and seconds counters in 24-hour format.
- Provides a button-driven set mode for adjusting hours and minutes.
- Its 6-bit outputs feed the binary-to-BCD converter stage, one converter per field, ahead of the display driver.

Parameters:
- TICK_DIV, 100000000, clock cycles per 1 s tick; legal range >= 2. Benches use 4.

Ports:
- clk_i  input  1  system clock; all logic on rising edge
- rst_n_i  input  1  synchronous active-low reset
- mode_btn_i  input  1  mode button level; already synchronised and debounced upstream
- inc_btn_i  input  1  increment button level; already synchronised and debounced upstream
- hours_o  output  6  binary hours, 0..23
- minutes_o  output  6  binary minutes, 0..59
- seconds_o  output  6  binary seconds, 0..59
- mode_o  output  2  00 RUN, 01 SET_HOUR, 10 SET_MIN; 11 never driven
- tick_o  output  1  one-cycle pulse marking each seconds update in RUN

Behaviour:
- Interface: one clock, clk_i. rst_n_i is synchronous and active-low. All outputs are registered.
- Reset (rst_n_i=0 at a clock edge):
  - hours_o, minutes_o, seconds_o = 0; tick_o = 0; mode_o = RUN.
  - Prescaler = 0.
  - Button history registers = 1, so a button held through reset generates no edge.
- Edge detect:
  - A press is a cycle where btn_i=1 and its history register=0.
  - The history register follows btn_i every cycle.
  - The effect of a press is visible on outputs the cycle after the detecting edge.
  - Holding a button produces exactly one press.
- Prescaler (RUN only):
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - On the wrap edge, seconds advance and tick_o=1 for the following cycle only.
  - First tick after reset: seconds_o=1 and tick_o=1 visible TICK_DIV cycles after rst_n_i deasserts.
- Time carry (RUN):
  - seconds 59 -> 0 with minutes +1.
  - minutes 59 -> 0 with hours +1.
  - hours 23 -> 0.
  - All carries complete in the same cycle, so 23:59:59 -> 00:00:00 in one update.
- Mode FSM:
  - A mode press advances RUN -> SET_HOUR -> SET_MIN -> RUN.
  - Entering SET_HOUR clears seconds and the prescaler. Both are held at 0 with tick_o=0 while in either SET state.
  - Returning to RUN restarts the prescaler from 0, so the first tick comes TICK_DIV cycles later.
- Increment:
  - SET_HOUR: an inc press sets hours = (hours+1) mod 24; minutes are untouched.
  - SET_MIN: an inc press sets minutes = (minutes+1) mod 60; no carry into hours.
  - RUN: inc presses are ignored.
- Simultaneous events:
  - Mode and inc press in the same cycle: mode wins; the inc press is discarded and the field is unchanged.
  - A mode press coinciding with a prescaler wrap in RUN: the mode transition wins. No tick is issued and seconds are cleared.
- Reset mid-operation: reset overrides everything in any state, including mid-SET and mid-carry.
- Out-of-range values are unreachable. The implementation uses explicit compare-and-wrap logic, not modulo of wider arithmetic.

Test Plan:
1. Reset and tick:
   - Stimulus: TICK_DIV=4; hold rst_n_i=0 for 3 cycles, then release.
   - Required: all outputs 0 and mode_o=00 during reset.
   - Required: tick_o pulses exactly every 4 cycles; seconds_o=1,2,3 after 4, 8, 12 cycles.
2. Full rollover:
   - Stimulus: set 23:59 via SET_HOUR (23 presses) and SET_MIN (59 presses); return to RUN; run 60 ticks.
   - Required: 23:59:59 -> 00:00:00 on a single tick edge.
3. Set-field wrap:
   - Stimulus: in SET_HOUR, 24 inc presses; in SET_MIN, 61 inc presses.
   - Required: hours return to start value; minutes=1; hours unchanged by the minute wrap; seconds_o=0 and tick_o=0 throughout.
4. Simultaneous presses:
   - Stimulus: in SET_HOUR, assert mode_btn_i and inc_btn_i rising in the same cycle.
   - Required: mode_o=10 next cycle; hours unchanged.
5. Held and pre-reset buttons:
   - Stimulus: hold inc_btn_i high 10 cycles in SET_MIN.
   - Required: minutes +1 only.
   - Stimulus: hold mode_btn_i high across reset release.
   - Required: mode_o stays 00.
6. Reset mid-set:
   - Stimulus: in SET_MIN at 14:37, assert rst_n_i=0 for one edge.
   - Required: next cycle 00:00:00, mode_o=00; first tick 4 cycles after release.
